// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file writeback types and constants.
// Used by regfile_wb_arbiter; bypass build option: REGFILE_WB_BYPASS_EN.
package regfile_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam int REG_ZERO  = 0;
    localparam int REG_V0    = 2;
    localparam int REG_COUNT = 32;
    localparam int DATA_W    = 32;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer advances past the winner.
// Reusable for any N-way single-port sharing.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // Two passes: from the pointer upward, then wrap to the low indices.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && i >= int'(ptr_q)) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                ptr_d      = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && i < int'(ptr_q)) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                ptr_d      = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback port arbiter with pending-write scoreboard for the register file.
// Define REGFILE_WB_BYPASS_EN to add same-cycle forwarding lookups.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      claim_valid,
    input  logic [ADDR_W-1:0]         claim_reg,
    output logic                      regwrite,
    output logic [ADDR_W-1:0]         writereg,
    output logic [DATA_W-1:0]         writedata,
    output logic [REG_COUNT-1:0]      pending,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [ADDR_W-1:0]         lookup_reg1,
    input  logic [ADDR_W-1:0]         lookup_reg2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [DATA_W-1:0]         fwd_data1,
    output logic [DATA_W-1:0]         fwd_data2,
`endif
    output logic                      busy
);

    logic [NUM_REQ-1:0]   req_m;
    logic [NUM_REQ-1:0]   grant;
    logic                 hs;
    logic [ADDR_W-1:0]    win_reg;
    logic [DATA_W-1:0]    win_data;
    logic                 win_real;

    logic                 regwrite_q;
    logic [ADDR_W-1:0]    writereg_q;
    logic [DATA_W-1:0]    writedata_q;
    logic [REG_COUNT-1:0] pending_q;
    logic [REG_COUNT-1:0] pending_d;

    assign req_m = reset ? '0 : req_valid;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req_m),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign hs        = |grant;

    always_comb begin
        win_reg  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_reg  = req_reg[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign win_real = hs && (win_reg != ADDR_W'(REG_ZERO));

    // Claim is applied after the clear so a same-edge claim wins.
    always_comb begin
        pending_d = pending_q;
        if (hs) begin
            pending_d[win_reg] = 1'b0;
        end
        if (claim_valid) begin
            pending_d[claim_reg] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
            pending_q   <= '0;
        end else begin
            regwrite_q <= win_real;
            pending_q  <= pending_d;
            if (win_real) begin
                writereg_q  <= win_reg;
                writedata_q <= win_data;
            end
        end
    end

    assign regwrite  = regwrite_q;
    assign writereg  = writereg_q;
    assign writedata = writedata_q;
    assign pending   = pending_q;
    assign busy      = |pending_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign fwd_hit1  = regwrite_q && (writereg_q == lookup_reg1)
                       && (lookup_reg1 != ADDR_W'(REG_ZERO));
    assign fwd_hit2  = regwrite_q && (writereg_q == lookup_reg2)
                       && (lookup_reg2 != ADDR_W'(REG_ZERO));
    assign fwd_data1 = fwd_hit1 ? writedata_q : '0;
    assign fwd_data2 = fwd_hit2 ? writedata_q : '0;
`endif

endmodule
